// File: rtl/vend_pkg.sv
// Shared definitions for the vending sequencer: credit width, coin values and FSM state encoding.
package vend_pkg;

    localparam int CREDIT_W = 4;

    localparam logic [CREDIT_W-1:0] COIN_HALF = 4'd1;
    localparam logic [CREDIT_W-1:0] COIN_ONE  = 4'd2;

    // One-hot encoding keeps each state decode to a single flop bit.
    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_CREDIT = 5'b00010,
        ST_VEND   = 5'b00100,
        ST_CHANGE = 5'b01000,
        ST_REFUND = 5'b10000
    } vend_state_e;

endpackage

// File: rtl/vend_coin_acc.sv
// Coin-pulse decode for the vending sequencer: classifies each pulse as accepted or rejected
// and forms the candidate credit sum; the owning FSM decides whether to load it.
module vend_coin_acc
    import vend_pkg::*;
(
    input  logic                coin_half,
    input  logic                coin_one,
    input  logic                accept_en,
    input  logic [CREDIT_W-1:0] credit_in,
    output logic                coin_accept,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit_sum
);

    logic                any_coin;
    logic                both_coins;
    logic [CREDIT_W-1:0] coin_val;
    logic [CREDIT_W:0]   wide_sum;

    // The extra sum bit flags a coin that would carry credit past its maximum.
    always_comb begin
        any_coin    = coin_half | coin_one;
        both_coins  = coin_half & coin_one;
        coin_val    = coin_one ? COIN_ONE : COIN_HALF;
        wide_sum    = {1'b0, credit_in} + {1'b0, coin_val};
        coin_accept = any_coin && !both_coins && accept_en && !wide_sum[CREDIT_W];
        coin_reject = any_coin && !coin_accept;
        credit_sum  = wide_sum[CREDIT_W-1:0];
    end

endmodule

// File: rtl/vend_seq_ctrl.sv
// Vending sequencer: coin credit, drink dispense and half-coin change/refund handshakes.
// Build option: define VEND_CHANGE_EN to pay out excess credit as change after a vend.
module vend_seq_ctrl
    import vend_pkg::*;
#(
    parameter int          PRICE   = 4,
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic                sys_clk,
    input  logic                sysRst,
    input  logic                piHalf,
    input  logic                piOne,
    input  logic                piCancel,
    input  logic                piDispAck,
    input  logic                piHopAck,
    output logic                oDispReq,
    output logic                oHopReq,
    output logic                oCoinRej,
    output logic [CREDIT_W-1:0] oCredit,
    output logic                oBusy
);

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    vend_state_e         state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [15:0]         idle_cnt_q, idle_cnt_d;
    logic                hop_req_q, hop_req_d;
    logic                coin_rej_q, coin_rej_d;
    logic                accept_en;
    logic                coin_accept;
    logic                coin_reject;
    logic [CREDIT_W-1:0] coin_sum;

    assign accept_en = (state_q == ST_IDLE) || (state_q == ST_CREDIT);

    vend_coin_acc u_coin_acc (
        .coin_half   (piHalf),
        .coin_one    (piOne),
        .accept_en   (accept_en),
        .credit_in   (credit_q),
        .coin_accept (coin_accept),
        .coin_reject (coin_reject),
        .credit_sum  (coin_sum)
    );

    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        idle_cnt_d = idle_cnt_q;
        hop_req_d  = hop_req_q;
        coin_rej_d = coin_reject;
        case (state_q)
            ST_IDLE: begin
                idle_cnt_d = '0;
                if (coin_accept) begin
                    credit_d = coin_sum;
                    state_d  = ST_CREDIT;
                end
            end
            ST_CREDIT: begin
                if (coin_accept) begin
                    credit_d   = coin_sum;
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + 16'd1;
                end
                // A coin landing with cancel still counts, so REFUND returns the full total.
                if (credit_q >= PRICE_C) begin
                    state_d    = ST_VEND;
                    credit_d   = credit_d - PRICE_C;
                    idle_cnt_d = '0;
                end else if (piCancel || (!coin_accept && idle_cnt_d >= TIMEOUT)) begin
                    state_d    = ST_REFUND;
                    idle_cnt_d = '0;
                end
            end
            ST_VEND: begin
                if (piDispAck) begin
`ifdef VEND_CHANGE_EN
                    state_d = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
`else
                    state_d  = ST_IDLE;
                    credit_d = '0;
`endif
                end
            end
            ST_CHANGE, ST_REFUND: begin
                // Four-phase: request only once the hopper has released its previous ack.
                if (hop_req_q) begin
                    if (piHopAck) begin
                        hop_req_d = 1'b0;
                        credit_d  = credit_q - COIN_HALF;
                    end
                end else if (credit_q == '0) begin
                    state_d = ST_IDLE;
                end else if (!piHopAck) begin
                    hop_req_d = 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                credit_d   = '0;
                idle_cnt_d = '0;
                hop_req_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sysRst) begin
            state_q    <= ST_IDLE;
            credit_q   <= '0;
            idle_cnt_q <= '0;
            hop_req_q  <= 1'b0;
            coin_rej_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            idle_cnt_q <= idle_cnt_d;
            hop_req_q  <= hop_req_d;
            coin_rej_q <= coin_rej_d;
        end
    end

    assign oDispReq = (state_q == ST_VEND);
    assign oHopReq  = hop_req_q;
    assign oCoinRej = coin_rej_q;
    assign oCredit  = credit_q;
    assign oBusy    = (state_q == ST_VEND) || (state_q == ST_CHANGE) || (state_q == ST_REFUND);

endmodule

// File: tb/tb_vend_seq_ctrl.sv
// Self-checking bench for vend_seq_ctrl: per-cycle vector table plus handshake-driven sequences.
// Expectations for the change path follow the VEND_CHANGE_EN build option.
module tb_vend_seq_ctrl;

    typedef struct packed {
        logic [3:0] credit;
        logic       rej;
        logic       disp;
        logic       hop;
        logic       busy;
    } outs_t;

    typedef struct {
        logic  rst;
        logic  half;
        logic  one;
        logic  cancel;
        logic  dack;
        logic  hack;
        outs_t exp;
    } vec_t;

    logic       sys_clk = 1'b0;
    logic       sysRst;
    logic       piHalf, piOne, piCancel, piDispAck, piHopAck;
    logic       oDispReq, oHopReq, oCoinRej, oBusy;
    logic [3:0] oCredit;

    vec_t  vec_table[$];
    outs_t exp_q[$];
    int    credit_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    vend_seq_ctrl #(.PRICE(4), .TIMEOUT(16'd10)) dut (
        .sys_clk   (sys_clk),
        .sysRst    (sysRst),
        .piHalf    (piHalf),
        .piOne     (piOne),
        .piCancel  (piCancel),
        .piDispAck (piDispAck),
        .piHopAck  (piHopAck),
        .oDispReq  (oDispReq),
        .oHopReq   (oHopReq),
        .oCoinRej  (oCoinRej),
        .oCredit   (oCredit),
        .oBusy     (oBusy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic checkVal(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic addVec(input logic rst, input logic half, input logic one, input logic cancel,
                          input logic dack, input logic hack, input logic [3:0] credit,
                          input logic rej, input logic disp, input logic hop, input logic busy);
        vec_t v;
        v.rst = rst; v.half = half; v.one = one; v.cancel = cancel; v.dack = dack; v.hack = hack;
        v.exp = '{credit: credit, rej: rej, disp: disp, hop: hop, busy: busy};
        vec_table.push_back(v);
    endtask

    task automatic clearInputs();
        sysRst = 1'b0; piHalf = 1'b0; piOne = 1'b0; piCancel = 1'b0;
        piDispAck = 1'b0; piHopAck = 1'b0;
    endtask

    task automatic checkOutput(input string name);
        outs_t act;
        outs_t exp;
        act = {oCredit, oCoinRej, oDispReq, oHopReq, oBusy};
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected queue empty", name, act);
        end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
                n_fail++;
                $display("[TB] FAIL %s: got credit=%0d rej=%b disp=%b hop=%b busy=%b, expected credit=%0d rej=%b disp=%b hop=%b busy=%b",
                         name, act.credit, act.rej, act.disp, act.hop, act.busy,
                         exp.credit, exp.rej, exp.disp, exp.hop, exp.busy);
            end
        end
    endtask

    // Called at a falling edge: drive one cycle of inputs, then compare at the next falling edge.
    task automatic applyStimulus(input vec_t v, input string name);
        sysRst = v.rst; piHalf = v.half; piOne = v.one; piCancel = v.cancel;
        piDispAck = v.dack; piHopAck = v.hack;
        exp_q.push_back(v.exp);
        @(negedge sys_clk);
        checkOutput(name);
    endtask

    // Dispenser and hopper responders mirror the requests; stops once the busy phase ends.
    task automatic runTransaction(input string name, input int exp_vends, input int exp_hops);
        int   vends = 0;
        int   hops  = 0;
        bit   seen_busy = 1'b0;
        bit   done = 1'b0;
        logic prev_hop = 1'b0;
        logic prev_disp = 1'b0;
        clearInputs();
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge sys_clk);
            if (oHopReq && !prev_hop) begin
                hops++;
                if (credit_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL %s_hop_credit: got credit %0d at an unexpected request, expected no request",
                             name, oCredit);
                end else begin
                    checkVal({name, "_hop_credit"}, oCredit, credit_q.pop_front());
                end
            end
            if (oDispReq && !prev_disp) vends++;
            prev_hop  = oHopReq;
            prev_disp = oDispReq;
            piHopAck  = oHopReq;
            piDispAck = oDispReq;
            if (oBusy) seen_busy = 1'b1;
            else if (seen_busy) done = 1'b1;
        end
        clearInputs();
        checkVal({name, "_completed"}, int'(done), 1);
        checkVal({name, "_vends"}, vends, exp_vends);
        checkVal({name, "_hops"}, hops, exp_hops);
        checkVal({name, "_final_credit"}, oCredit, 0);
        checkVal({name, "_unused_hop_expect"}, credit_q.size(), 0);
        credit_q.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int idle_cycles;
        vec_t v;
        clearInputs();
        sysRst = 1'b1;
        repeat (2) @(negedge sys_clk);

        //      rst h o c da ha  credit rej disp hop busy
        addVec(1, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0);
        addVec(0, 0, 1, 0, 0, 0, 4'd2, 0, 0, 0, 0);
        addVec(0, 0, 1, 0, 0, 0, 4'd4, 0, 0, 0, 0);
        addVec(0, 0, 0, 0, 0, 0, 4'd0, 0, 1, 0, 1);
        addVec(0, 0, 0, 0, 0, 0, 4'd0, 0, 1, 0, 1);
        addVec(0, 1, 0, 0, 0, 0, 4'd0, 1, 1, 0, 1);
        addVec(0, 0, 0, 0, 1, 0, 4'd0, 0, 0, 0, 0);
        addVec(0, 0, 0, 0, 1, 0, 4'd0, 0, 0, 0, 0);
        addVec(0, 1, 1, 0, 0, 0, 4'd0, 1, 0, 0, 0);
        addVec(0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0);
        addVec(0, 1, 0, 0, 0, 0, 4'd1, 0, 0, 0, 0);
        addVec(0, 1, 1, 0, 0, 0, 4'd1, 1, 0, 0, 0);
        addVec(0, 0, 0, 0, 1, 0, 4'd1, 0, 0, 0, 0);
        addVec(0, 0, 0, 0, 0, 1, 4'd1, 0, 0, 0, 0);
        addVec(0, 0, 0, 1, 0, 0, 4'd1, 0, 0, 0, 1);
        addVec(0, 0, 0, 0, 0, 0, 4'd1, 0, 0, 1, 1);
        addVec(0, 0, 0, 0, 0, 1, 4'd0, 0, 0, 0, 1);
        addVec(0, 0, 0, 0, 0, 1, 4'd0, 0, 0, 0, 0);
        addVec(0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0);
        addVec(0, 0, 0, 1, 0, 0, 4'd0, 0, 0, 0, 0);
        addVec(0, 0, 1, 0, 0, 0, 4'd2, 0, 0, 0, 0);
        addVec(0, 0, 0, 1, 0, 0, 4'd2, 0, 0, 0, 1);
        addVec(0, 0, 0, 0, 0, 0, 4'd2, 0, 0, 1, 1);
        addVec(1, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0);
        addVec(0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0);
        addVec(0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0);

        for (int i = 0; i < vec_table.size(); i++) begin
            applyStimulus(vec_table[i], $sformatf("vec%0d", i));
        end
        clearInputs();

        // One, half, one gives credit 5: one vend, then change of a single half coin if enabled.
        addVec(0, 0, 1, 0, 0, 0, 4'd2, 0, 0, 0, 0);
        addVec(0, 1, 0, 0, 0, 0, 4'd3, 0, 0, 0, 0);
        addVec(0, 0, 1, 0, 0, 0, 4'd5, 0, 0, 0, 0);
        for (int i = vec_table.size() - 3; i < vec_table.size(); i++) begin
            applyStimulus(vec_table[i], $sformatf("change_coin%0d", i));
        end
`ifdef VEND_CHANGE_EN
        credit_q.push_back(1);
        runTransaction("change", 1, 1);
`else
        runTransaction("change", 1, 0);
`endif

        // Cancel after half + one refunds three half coins, credit 3 -> 2 -> 1 -> 0.
        addVec(0, 1, 0, 0, 0, 0, 4'd1, 0, 0, 0, 0);
        addVec(0, 0, 1, 0, 0, 0, 4'd3, 0, 0, 0, 0);
        addVec(0, 0, 0, 1, 0, 0, 4'd3, 0, 0, 0, 1);
        for (int i = vec_table.size() - 3; i < vec_table.size(); i++) begin
            applyStimulus(vec_table[i], $sformatf("refund_step%0d", i));
        end
        credit_q.push_back(3);
        credit_q.push_back(2);
        credit_q.push_back(1);
        runTransaction("refund", 0, 3);

        // A lone half coin left idle for TIMEOUT cycles is refunded automatically.
        v.rst = 0; v.half = 1; v.one = 0; v.cancel = 0; v.dack = 0; v.hack = 0;
        v.exp = '{credit: 4'd1, rej: 1'b0, disp: 1'b0, hop: 1'b0, busy: 1'b0};
        applyStimulus(v, "timeout_coin");
        clearInputs();
        idle_cycles = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge sys_clk);
            if (oBusy) begin
                idle_cycles = k;
                break;
            end
        end
        checkVal("timeout_idle_cycles", idle_cycles, 10);
        credit_q.push_back(1);
        runTransaction("timeout", 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vend_seq_ctrl.md
VEND_SEQ_CTRL -- requirements
Module: vend_seq_ctrl

Interface
REQ-001 SHALL have parameter PRICE, default 4, drink price in half-unit (0.5) coins, legal range 1..14.
REQ-002 SHALL have parameter TIMEOUT, default 16'd50000, idle cycles in CREDIT before an automatic refund.
REQ-003 SHALL have port sys_clk, input, 1, the single clock; every flop is on its rising edge.
REQ-004 SHALL have port sysRst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port piHalf, input, 1, one-cycle pulse for a 0.5 coin.
REQ-006 SHALL have port piOne, input, 1, one-cycle pulse for a 1.0 coin.
REQ-007 SHALL have port piCancel, input, 1, one-cycle refund request.
REQ-008 SHALL have port piDispAck, input, 1, dispenser done (level, held until oDispReq drops).
REQ-009 SHALL have port piHopAck, input, 1, hopper ejected one 0.5 coin (level, held until oHopReq drops).
REQ-010 SHALL have port oDispReq, output, 1, dispense-drink request.
REQ-011 SHALL have port oHopReq, output, 1, eject-one-half-coin request.
REQ-012 SHALL have port oCoinRej, output, 1, one-cycle pulse: coin rejected and returned mechanically.
REQ-013 SHALL have port oCredit, output, 4, current credit in half units.
REQ-014 SHALL have port oBusy, output, 1, high in VEND, CHANGE and REFUND.

Function
REQ-015 SHALL implement FSM states IDLE, CREDIT, VEND, CHANGE, REFUND; the encoding is one-hot.
REQ-016 SHALL add coins in IDLE/CREDIT as piHalf = +1 and piOne = +2, registered, so oCredit updates one cycle after the pulse.
REQ-017 SHALL treat piHalf and piOne in the same cycle as invalid: credit unchanged, oCoinRej pulsed.
REQ-018 SHALL reject any coin arriving in VEND/CHANGE/REFUND (oCoinRej pulse) and SHALL reject any coin that would push credit above 15, leaving credit unchanged.
REQ-019 SHALL transition IDLE -> CREDIT on the first accepted coin.
REQ-020 SHALL transition CREDIT -> VEND in the cycle after credit becomes >= PRICE, asserting oDispReq from VEND entry.
REQ-021 SHALL subtract PRICE from credit on VEND entry.
REQ-022 SHALL deassert oDispReq the cycle after piDispAck=1, then go to CHANGE if credit > 0 (with VEND_CHANGE_EN), else to IDLE.
REQ-023 SHALL, in CHANGE/REFUND, run one oHopReq/piHopAck four-phase handshake per half unit: oHopReq rises, waits for piHopAck=1, falls with credit decremented, and waits for piHopAck=0 before the next request; the state exits to IDLE when credit reaches 0.
REQ-024 SHALL go CREDIT -> REFUND on piCancel or when the idle counter reaches TIMEOUT; any accepted coin restarts the idle counter.
REQ-025 SHALL give a coin accepted in the same cycle as piCancel priority (credit updated), with REFUND then returning the full total.
REQ-026 SHALL ignore piCancel in IDLE, VEND and CHANGE.
REQ-027 SHALL ignore piDispAck outside VEND and piHopAck outside CHANGE/REFUND.

Reset
REQ-028 SHALL, with sysRst=1 at a clock edge, set state to IDLE, credit and idle counter to 0, and oDispReq, oHopReq, oCoinRej and oBusy to 0.
REQ-029 SHALL let reset mid-VEND/CHANGE/REFUND abort the handshake and discard credit; no refund is owed after reset.

Configuration
REQ-030 SHALL, with VEND_CHANGE_EN defined, return excess credit via CHANGE after a vend.
REQ-031 SHALL, with VEND_CHANGE_EN undefined, clear excess credit on VEND exit and never enter CHANGE from VEND; REFUND is unaffected.

Structure
REQ-032 SHALL place the state enum, the coin values (HALF=1, ONE=2) and the credit width (4) in shared package vend_pkg.
REQ-033 SHALL put the coin-pulse decode, reject and credit-add logic in sub-module vend_coin_acc; the FSM and handshakes stay in vend_seq_ctrl.

Verification
REQ-034 SHALL cover: PRICE=4, piOne,piOne -> oDispReq rises 2 cycles after the second pulse; ack -> IDLE, credit 0, no oHopReq.
REQ-035 SHALL cover: PRICE=4, piOne,piHalf,piOne (5) with VEND_CHANGE_EN -> one vend then exactly 1 oHopReq handshake; without the macro -> 0 handshakes, credit 0.
REQ-036 SHALL cover: piHalf,piOne then piCancel -> REFUND with 3 oHopReq handshakes, oCredit 3->2->1->0, then IDLE.
REQ-037 SHALL cover: piHalf and piOne in the same cycle, and a coin during VEND -> oCoinRej pulses for 1 cycle, credit unchanged.
REQ-038 SHALL cover: TIMEOUT=10, one piHalf then 10 idle cycles -> REFUND entered, 1 handshake.
REQ-039 SHALL cover: sysRst asserted while oHopReq=1 -> next cycle state IDLE and all outputs 0.
